// File: rtl/sm83_bus_ctl.sv
// SM83 external bus controller: runs one T1..T4 machine cycle per request,
// with wait-state insertion, a bounded wait timeout and internal high-page decode.
module sm83_bus_ctl #(
  parameter int unsigned ADR_WIDTH = 16,
  parameter int unsigned MAX_WAIT  = 15,
  parameter logic [7:0]  HI_PAGE   = 8'hFE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADR_WIDTH-1:0] adr,
  input  logic                 req,
  input  logic                 we,
  input  logic [7:0]           wdata,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           rdata,
  output logic                 timeout,
  output logic [ADR_WIDTH-1:0] ext_adr,
  output logic [7:0]           ext_dout,
  output logic                 ext_oe,
  input  logic [7:0]           ext_din,
  output logic                 ext_rd_n,
  output logic                 ext_wr_n,
  output logic                 ext_cs_n,
  output logic                 int_sel,
  input  logic                 ext_wait_n
);

  typedef enum logic [2:0] {StIdle, StT1, StT2, StT3, StT4} state_e;

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  state_e               r_state, w_state_d;
  logic [3:0]           r_cnt, w_cnt_d, w_eval_cnt;
  logic                 r_last, w_last_d;
  logic                 r_forced, w_forced_d;
  logic                 r_we, w_we_d;
  logic                 r_int_sel, w_int_sel_d;
  logic [ADR_WIDTH-1:0] r_ext_adr, w_adr_d;
  logic [7:0]           r_ext_dout, w_dout_d;
  logic [7:0]           r_rdata, w_rdata_d;
  logic                 r_busy, w_busy_d;
  logic                 r_done, w_done_d;
  logic                 r_timeout, w_timeout_d;
  logic                 r_oe, w_oe_d;
  logic                 r_rd_n, w_rd_n_d;
  logic                 r_wr_n, w_wr_n_d;
  logic                 r_cs_n, w_cs_n_d;
  logic                 w_capture;
  logic                 w_t3_eval;

  // Wait is pre-sampled on the edge entering each T3 cycle, so r_last already
  // tells whether the current T3 cycle is the final one and ext_wr_n can be a flop.
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_last_d   = r_last;
    w_forced_d = r_forced;
    w_t3_eval  = 1'b0;
    w_eval_cnt = r_cnt;
    w_capture  = req & ((r_state == StIdle) | (r_state == StT4));

    case (r_state)
      StIdle: if (req) w_state_d = StT1;
      StT1:   w_state_d = StT2;
      StT2: begin
        w_state_d  = StT3;
        w_t3_eval  = 1'b1;
        w_eval_cnt = 4'd0;
      end
      StT3: begin
        if (r_last) begin
          w_state_d = StT4;
        end else begin
          w_t3_eval  = 1'b1;
          w_eval_cnt = r_cnt + 4'd1;
        end
      end
      StT4:    w_state_d = req ? StT1 : StIdle;
      default: w_state_d = StIdle;
    endcase

    if (w_capture) w_cnt_d = 4'd0;
    if (w_t3_eval) begin
      w_cnt_d    = w_eval_cnt;
      w_last_d   = r_int_sel | ext_wait_n | (w_eval_cnt == MaxWait);
      w_forced_d = ~r_int_sel & ~ext_wait_n & (w_eval_cnt == MaxWait);
    end
  end

  always_comb begin
    w_we_d      = w_capture ? we : r_we;
    w_int_sel_d = w_capture ? (adr[ADR_WIDTH-1 -: 8] >= HI_PAGE) : r_int_sel;
    w_adr_d     = w_capture ? adr : r_ext_adr;
    w_dout_d    = (w_capture & we) ? wdata : r_ext_dout;
    w_rdata_d   = ((r_state == StT3) & r_last & ~r_we) ? ext_din : r_rdata;
    w_busy_d    = (w_state_d != StIdle);
    w_done_d    = (w_state_d == StT4);
    w_timeout_d = w_done_d & (r_state == StT3) & r_forced;
    w_cs_n_d    = ~(w_busy_d & ~w_int_sel_d);
    w_rd_n_d    = ~(~w_we_d & ((w_state_d == StT2) | (w_state_d == StT3)));
    w_oe_d      = w_we_d & ((w_state_d == StT2) | (w_state_d == StT3) | (w_state_d == StT4));
    w_wr_n_d    = ~(w_we_d & (w_state_d == StT3) & w_last_d);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_cnt      <= 4'd0;
      r_last     <= 1'b0;
      r_forced   <= 1'b0;
      r_we       <= 1'b0;
      r_int_sel  <= 1'b0;
      r_ext_adr  <= '0;
      r_ext_dout <= 8'd0;
      r_rdata    <= 8'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_oe       <= 1'b0;
      r_rd_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_cs_n     <= 1'b1;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_last     <= w_last_d;
      r_forced   <= w_forced_d;
      r_we       <= w_we_d;
      r_int_sel  <= w_int_sel_d;
      r_ext_adr  <= w_adr_d;
      r_ext_dout <= w_dout_d;
      r_rdata    <= w_rdata_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_timeout  <= w_timeout_d;
      r_oe       <= w_oe_d;
      r_rd_n     <= w_rd_n_d;
      r_wr_n     <= w_wr_n_d;
      r_cs_n     <= w_cs_n_d;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rdata    = r_rdata;
  assign timeout  = r_timeout;
  assign ext_adr  = r_ext_adr;
  assign ext_dout = r_ext_dout;
  assign ext_oe   = r_oe;
  assign ext_rd_n = r_rd_n;
  assign ext_wr_n = r_wr_n;
  assign ext_cs_n = r_cs_n;
  assign int_sel  = r_int_sel;

endmodule

// File: tb/tb_sm83_bus_ctl.sv
// Directed bench for sm83_bus_ctl: a phase-level model predicts every output each
// cycle, and literal counts/latencies pin the model on the documented scenarios.
module tb_sm83_bus_ctl;

  localparam int MAXW = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] adr;
  logic        req;
  logic        we;
  logic [7:0]  wdata;
  logic        busy, done, timeout, ext_oe, ext_rd_n, ext_wr_n, ext_cs_n, int_sel;
  logic [7:0]  rdata, ext_dout, ext_din;
  logic [15:0] ext_adr;
  logic        ext_wait_n;

  always #5 clk = ~clk;

  sm83_bus_ctl #(
    .ADR_WIDTH(16),
    .MAX_WAIT (MAXW),
    .HI_PAGE  (8'hFE)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .adr       (adr),
    .req       (req),
    .we        (we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .timeout   (timeout),
    .ext_adr   (ext_adr),
    .ext_dout  (ext_dout),
    .ext_oe    (ext_oe),
    .ext_din   (ext_din),
    .ext_rd_n  (ext_rd_n),
    .ext_wr_n  (ext_wr_n),
    .ext_cs_n  (ext_cs_n),
    .int_sel   (int_sel),
    .ext_wait_n(ext_wait_n)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs for the current cycle.
  logic        e_busy, e_done, e_tmo, e_cs_n, e_rd_n, e_wr_n, e_oe, e_int_sel;
  logic [15:0] e_adr;
  logic [7:0]  e_dout, e_rdata;

  // Model state held across accesses.
  logic [15:0] m_adr;
  logic [7:0]  m_dout, m_rdata;
  logic        m_int_sel;

  // Current transaction, in terms of phases: T1, T2, n3 x T3, T4.
  logic        t_we, t_forced;
  logic [7:0]  t_din;
  int          t_n3;

  int cnt_cs, cnt_rd, cnt_wr, cnt_oe, cnt_done, cnt_tmo, run, max_run, last_done, req_cyc;
  int done_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic clr_counts();
    cnt_cs = 0; cnt_rd = 0; cnt_wr = 0; cnt_oe = 0; cnt_done = 0; cnt_tmo = 0;
    run = 0; max_run = 0; last_done = -1000;
    done_q.delete();
  endtask

  task automatic set_idle();
    e_busy = 0; e_done = 0; e_tmo = 0; e_cs_n = 1; e_rd_n = 1; e_wr_n = 1; e_oe = 0;
    e_int_sel = m_int_sel; e_adr = m_adr; e_dout = m_dout; e_rdata = m_rdata;
  endtask

  task automatic set_phase(input int p);
    e_busy    = 1;
    e_done    = (p == t_n3 + 2);
    e_tmo     = e_done && t_forced;
    e_int_sel = m_int_sel;
    e_cs_n    = m_int_sel;
    e_rd_n    = !(!t_we && p >= 1 && p <= t_n3 + 1);
    e_oe      = t_we && p >= 1;
    e_wr_n    = !(t_we && p == t_n3 + 1);
    e_adr     = m_adr;
    e_dout    = m_dout;
    if (e_done && !t_we) m_rdata = t_din;
    e_rdata   = m_rdata;
  endtask

  task automatic idle(input int n);
    req = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ext_wait_n = 1;
      set_idle();
    end
  endtask

  // Drives req in the current cycle and returns in the T4 cycle (or after a reset abort).
  // nw = cycles that ext_wait_n is held low starting in T2.
  task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d,
                        input logic [7:0] din, input int nw, input int abort_p);
    adr = a; we = w; wdata = d; req = 1; req_cyc = cyc;
    @(posedge clk); #1;
    req = 0; adr = 16'($urandom); we = 1'($urandom); wdata = 8'($urandom);
    m_adr = a;
    m_int_sel = (a[15:8] >= 8'hFE);
    if (w) m_dout = d;
    t_we = w; t_din = din;
    t_n3 = m_int_sel ? 1 : (((nw < MAXW) ? nw : MAXW) + 1);
    t_forced = !m_int_sel && (nw > MAXW);
    for (int p = 0; p <= t_n3 + 2; p++) begin
      if (p > 0) begin
        @(posedge clk); #1;
      end
      set_phase(p);
      ext_wait_n = (p >= 1 && p <= nw) ? 1'b0 : 1'b1;
      ext_din = (p == t_n3 + 1) ? din : ~din;
      if (p == abort_p) begin
        reset_n = 0;
        @(posedge clk); #1;
        reset_n = 1;
        ext_wait_n = 1;
        m_adr = 0; m_dout = 0; m_rdata = 0; m_int_sel = 0;
        set_idle();
        return;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("busy",     16'(busy),      16'(e_busy));
        chk("done",     16'(done),      16'(e_done));
        chk("timeout",  16'(timeout),   16'(e_tmo));
        chk("ext_cs_n", 16'(ext_cs_n),  16'(e_cs_n));
        chk("ext_rd_n", 16'(ext_rd_n),  16'(e_rd_n));
        chk("ext_wr_n", 16'(ext_wr_n),  16'(e_wr_n));
        chk("ext_oe",   16'(ext_oe),    16'(e_oe));
        chk("int_sel",  16'(int_sel),   16'(e_int_sel));
        chk("ext_adr",  ext_adr,        e_adr);
        if (e_oe) chk("ext_dout", 16'(ext_dout), 16'(e_dout));
        chk("rdata",    16'(rdata),     16'(e_rdata));
        if (ext_cs_n === 1'b0) cnt_cs++;
        if (ext_rd_n === 1'b0) cnt_rd++;
        if (ext_wr_n === 1'b0) cnt_wr++;
        if (ext_oe === 1'b1) cnt_oe++;
        if (timeout === 1'b1) cnt_tmo++;
        if (done === 1'b1) begin
          cnt_done++;
          last_done = cyc;
          done_q.push_back(cyc);
        end
        if (busy === 1'b1) begin
          run++;
          if (run > max_run) max_run = run;
        end else begin
          run = 0;
        end
      end
    end
  end

  initial begin
    reset_n = 0; req = 0; we = 0; adr = 0; wdata = 0; ext_din = 0; ext_wait_n = 1;
    m_adr = 0; m_dout = 0; m_rdata = 0; m_int_sel = 0;
    t_we = 0; t_forced = 0; t_din = 0; t_n3 = 1;
    clr_counts();
    set_idle();
    @(posedge clk); #1;
    chk_en = 1;
    set_idle();
    @(negedge clk);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_cs_n", 16'(ext_cs_n), 16'd1);
    @(posedge clk); #1;
    reset_n = 1;
    set_idle();
    idle(2);

    // Read, no wait.
    clr_counts();
    access(16'hC123, 1'b0, 8'h00, 8'h5A, 0, -1);
    idle(2);
    chk("rd_latency", 16'(last_done - req_cyc), 16'd4);
    chk("rd_cs_cycles", 16'(cnt_cs), 16'd4);
    chk("rd_rd_cycles", 16'(cnt_rd), 16'd2);
    chk("rd_rdata", 16'(rdata), 16'h005A);
    chk("rd_done_cnt", 16'(cnt_done), 16'd1);

    // Write with two wait states.
    clr_counts();
    access(16'h8000, 1'b1, 8'hA5, 8'h00, 2, -1);
    idle(2);
    chk("wr_latency", 16'(last_done - req_cyc), 16'd6);
    chk("wr_oe_cycles", 16'(cnt_oe), 16'd5);
    chk("wr_wr_cycles", 16'(cnt_wr), 16'd1);
    chk("wr_timeout_cnt", 16'(cnt_tmo), 16'd0);
    chk("wr_keeps_rdata", 16'(rdata), 16'h005A);

    // Wait held low: forced sample after MAX_WAIT extra T3 cycles.
    clr_counts();
    access(16'h4000, 1'b0, 8'h00, 8'h3C, 100, -1);
    idle(2);
    chk("tmo_latency", 16'(last_done - req_cyc), 16'd19);
    chk("tmo_timeout_cnt", 16'(cnt_tmo), 16'd1);
    chk("tmo_rdata", 16'(rdata), 16'h003C);

    // Wait exactly MAX_WAIT cycles: no timeout.
    clr_counts();
    access(16'h4001, 1'b1, 8'h96, 8'h00, MAXW, -1);
    idle(2);
    chk("maxw_latency", 16'(last_done - req_cyc), 16'd19);
    chk("maxw_timeout_cnt", 16'(cnt_tmo), 16'd0);

    // Internal region ignores wait; page boundaries.
    clr_counts();
    access(16'hFF80, 1'b0, 8'h00, 8'h77, 100, -1);
    idle(1);
    chk("int_latency", 16'(last_done - req_cyc), 16'd4);
    chk("int_cs_cycles", 16'(cnt_cs), 16'd0);
    chk("int_sel_ff80", 16'(int_sel), 16'd1);
    chk("int_rdata", 16'(rdata), 16'h0077);
    clr_counts();
    access(16'hFDFF, 1'b0, 8'h00, 8'h11, 0, -1);
    idle(1);
    chk("int_sel_fdff", 16'(int_sel), 16'd0);
    chk("fdff_cs_cycles", 16'(cnt_cs), 16'd4);
    access(16'hFE00, 1'b0, 8'h00, 8'h22, 3, -1);
    idle(1);
    chk("int_sel_fe00", 16'(int_sel), 16'd1);

    // Back-to-back reads with req held.
    clr_counts();
    access(16'h0100, 1'b0, 8'h00, 8'h01, 0, -1);
    access(16'h0101, 1'b0, 8'h00, 8'h02, 0, -1);
    access(16'h0102, 1'b0, 8'h00, 8'h03, 0, -1);
    idle(2);
    chk("b2b_busy_run", 16'(max_run), 16'd12);
    chk("b2b_done_cnt", 16'(cnt_done), 16'd3);
    for (int i = 1; i < done_q.size(); i++)
      chk("b2b_done_gap", 16'(done_q[i] - done_q[i-1]), 16'd4);
    chk("b2b_rdata", 16'(rdata), 16'h0003);

    // Reset during the final T3 of a write.
    clr_counts();
    access(16'h1234, 1'b1, 8'h9C, 8'h00, 0, 2);
    @(negedge clk);
    chk("abort_wr_n", 16'(ext_wr_n), 16'd1);
    chk("abort_oe", 16'(ext_oe), 16'd0);
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_rdata", 16'(rdata), 16'd0);
    idle(1);
    chk("abort_done_cnt", 16'(cnt_done), 16'd0);
    clr_counts();
    access(16'h2222, 1'b0, 8'h00, 8'h66, 1, -1);
    idle(2);
    chk("post_rst_latency", 16'(last_done - req_cyc), 16'd5);
    chk("post_rst_rdata", 16'(rdata), 16'h0066);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sm83_bus_ctl.md
# sm83_bus_ctl

Downstream of the SM83 address latch/incrementer: takes the latched address and a CPU-side request and runs one machine cycle of four T-states on the external memory bus. Drives address, data, and active-low read/write strobes, and decodes the internal high page. Honours a wait input with a bounded timeout and returns read data with a one-cycle completion pulse. All logic is on the rising edge of `clk`.

## Interface
- `ADR_WIDTH`, default 16: address width; must match the address latch.
- `MAX_WAIT`, default 15: maximum extra T3 cycles before a forced sample; 1..15.
- `HI_PAGE`, default 8'hFE: upper address byte threshold for the internal region.

Ports:
- `clk  in  1`: clock; all state changes on rising edge.
- `reset_n  in  1`: reset, synchronous and active-low.
- `adr  in  ADR_WIDTH`: latched address from the address latch output.
- `req  in  1`: request a machine cycle.
- `we  in  1`: 1 = write, 0 = read; qualified by `req`.
- `wdata  in  8`: write data; qualified by `req`.
- `busy  out  1`: a machine cycle is in progress (T1..T4).
- `done  out  1`: one-cycle pulse in T4.
- `rdata  out  8`: last completed read data.
- `timeout  out  1`: one-cycle pulse with `done` when the wait limit forced the sample.
- `ext_adr  out  ADR_WIDTH`: external address.
- `ext_dout  out  8`: external write data.
- `ext_oe  out  1`: external data bus drive enable.
- `ext_din  in  8`: external read data.
- `ext_rd_n  out  1`: read strobe, active low.
- `ext_wr_n  out  1`: write strobe, active low.
- `ext_cs_n  out  1`: external chip select, active low.
- `int_sel  out  1`: access targets the internal region.
- `ext_wait_n  in  1`: 0 = target not ready.

## Operation
- States: IDLE, T1, T2, T3, T4. Encoding is free; there are no other reachable states.
- **IDLE → T1.** Taken when `req`=1.
  - Capture `adr`, `we`, and `wdata` into internal registers.
  - `int_sel` = 1 when captured `adr[ADR_WIDTH-1 -: 8]` >= `HI_PAGE`; otherwise 0.
- **T1 → T2.** Unconditional.
  - `ext_adr` is valid from T1 through T4.
  - `ext_cs_n` = 0 from T1 through T4 when `int_sel`=0; held at 1 when `int_sel`=1.
- **T2 → T3.** Unconditional.
  - Read: `ext_rd_n` = 0 in T2 and T3.
  - Write: `ext_oe` = 1 and `ext_dout` = captured data in T2, T3 and T4.
- **T3 hold.** Stay in T3 while `ext_wait_n`=0, `int_sel`=0, and the wait counter < `MAX_WAIT`. The counter increments once per held cycle.
- **T3 → T4.** Taken when `ext_wait_n`=1, or `int_sel`=1 (internal region ignores wait), or the counter = `MAX_WAIT`.
  - Read: `rdata` <= `ext_din` on this edge.
  - Write: `ext_wr_n` = 0 for the final T3 cycle only (the cycle that exits T3).
  - If the exit was forced by the counter, `timeout` pulses in T4.
- **T4.**
  - `done` = 1 and `ext_rd_n` = 1.
  - If `req`=1, go to T1 and capture the new request (back-to-back, no IDLE cycle). Otherwise go to IDLE.
- The wait counter clears on entry to T1.
- `req` is ignored in T1, T2 and T3; no queuing.
- `ext_adr` holds its last value in IDLE.

## Timing
- Reset values (reset_n=0 on an edge):
  - state = IDLE.
  - `ext_adr`, `ext_dout`, `rdata` = 0.
  - `ext_rd_n`, `ext_wr_n`, `ext_cs_n` = 1.
  - `ext_oe`, `int_sel`, `busy`, `done`, `timeout` = 0.
  - Wait counter = 0.
- Reset mid-cycle aborts at the next edge:
  - Strobes release and `done` is not emitted.
  - `rdata` is cleared, not updated.
- Latency without wait: `req` sampled at edge N → `done` high during cycle N+4 → next `busy` cycle at N+5.
- Sustained throughput is one access per 4 clocks.
- With W wait cycles (W ≤ `MAX_WAIT`), `done` arrives at N+4+W. `ext_din` is sampled on the edge that leaves T3.
- All outputs are registered and glitch-free. Strobes change only on the `clk` rising edge.
- `rdata` is stable from T4 until the next read completes; writes do not alter it.
- `busy` = 1 exactly in T1..T4.

## Test plan
- **Read, no wait:** `adr`=16'hC123, `req`=1 for one cycle, `ext_din`=8'h5A, `ext_wait_n`=1.
  - `ext_cs_n`=0 for 4 cycles and `ext_rd_n`=0 for cycles 2-3.
  - `done` pulses on cycle 4 with `rdata`=8'h5A; `busy` drops after.
- **Write with 2 waits:** `adr`=16'h8000, `we`=1, `wdata`=8'hA5, `ext_wait_n`=0 for 2 T3 cycles.
  - `ext_oe`=1 for 5 cycles and `ext_wr_n`=0 only on the last T3 cycle.
  - `done` arrives 6 cycles after `req`; `timeout`=0.
- **Timeout:** `MAX_WAIT`=15, `ext_wait_n` held 0.
  - T3 lasts 16 cycles, then T4 shows `done`=1 and `timeout`=1.
  - `rdata` = `ext_din` value at exit.
- **Internal region:** `adr`=16'hFF80 read with `ext_wait_n`=0.
  - `int_sel`=1 and `ext_cs_n` stays 1.
  - No wait states; `done` at cycle 4.
  - Boundary check: `adr`=16'hFDFF gives `int_sel`=0.
- **Back-to-back:** `req` held 1 over three reads at 16'h0100, 16'h0101, 16'h0102.
  - `busy` stays 1 for 12 consecutive cycles with three `done` pulses 4 cycles apart.
- **Reset mid-cycle:** `reset_n`=0 during T3 of a write.
  - Next edge: `ext_wr_n`=1, `ext_oe`=0, state IDLE, no `done`.
  - A `req` after reset release starts a fresh T1.
